input_debounce_queue: RTL



---
 rtl/input_debounce_queue.sv | 119 +++++++++++
 1 files changed

// File: rtl/input_debounce_queue.sv
// rtl/input_debounce_queue.sv - button synchroniser, debouncer, press detector and event FIFO
module input_debounce_queue #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  ena,
  input  logic [WIDTH-1:0]                      btn_in,
  output logic [WIDTH-1:0]                      btn_state,
  output logic                                  cmd_valid,
  input  logic                                  cmd_ready,
  output logic [((WIDTH > 1) ? $clog2(WIDTH) : 1)-1:0] cmd_index,
  output logic                                  overflow,
  input  logic                                  overflow_clr
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = 8;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1, sync2, stable, pending;
  logic [WIDTH-1:0] flip, rise, grant;
  logic [CW-1:0]    cnt [WIDTH];
  logic [IW-1:0]    sel;
  logic [IW-1:0]    mem [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [PW:0]      count;
  logic             full, push, pop, coalesce;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
    end
  end

  // A flip happens on the edge where the counter has seen DEBOUNCE_CYCLES differing cycles.
  always_comb begin
    flip = '0;
    for (int i = 0; i < WIDTH; i++) begin
      flip[i] = (sync2[i] != stable[i]) && (cnt[i] == CNT_LAST);
    end
    rise = flip & ~stable;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stable <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else if (ena) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign btn_state = stable;
  assign full      = (count == (PW+1)'(FIFO_DEPTH));
  assign cmd_valid = (count != '0);
  assign pop       = cmd_valid && cmd_ready;
  assign cmd_index = mem[rd_ptr];

  // Lowest pending index wins; a full FIFO may still accept when it pops this cycle.
  always_comb begin
    sel = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (pending[i]) sel = IW'(i);
    end
    push  = ena && (|pending) && (!full || pop);
    grant = '0;
    if (push) grant[sel] = 1'b1;
    coalesce = ena && (|(rise & pending & ~grant));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      if (ena) pending <= (pending & ~grant) | rise;
      if (coalesce) overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= sel;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
